// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline latch/PC strobe and hazard sequencing controller
//
// Drives the write-enable and flush strobes of the IF/ID, ID/EX, EX/MEM and
// MEM/WB latches and the PC register. A small registered FSM tracks an
// outstanding data-cache miss and the halt condition.
//
// Optional feature macro: PIPE_STALL_CNT_EN (builds the saturating stall counter).
//
// Ports:
//   clk          core clock, rising edge
//   Rst          synchronous active-high reset
//   ihit         instruction fetch returned this cycle
//   dhit         data access in EX/MEM completed this cycle
//   mem_req      EX/MEM holds a load or store
//   load_use     ID/EX load feeds an IF/ID source register
//   redirect     EX/MEM resolved a taken control transfer
//   halt_in      EX/MEM holds a halt instruction
//   pc_wen       PC loads its next value
//   ifid_wen .. memwb_wen      latch capture enables
//   ifid_flush .. exmem_flush  latch loads a bubble (overrides wen)
//   halted       core is stopped
//   state        FSM state (RUN=0, MEMWAIT=1, HALTED=2)
//   stall_cycles stall cycle counter (0 when the counter is not built)

module pipe_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   mem_req,
  input  logic                   load_use,
  input  logic                   redirect,
  input  logic                   halt_in,
  output logic                   pc_wen,
  output logic                   ifid_wen,
  output logic                   idex_wen,
  output logic                   exmem_wen,
  output logic                   memwb_wen,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   halted,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t state_q;
  logic   halted_q;
  logic   mem_done;
  logic   advance;

  assign mem_done = mem_req & dhit;
  assign advance  = (state_q != HALTED) & ihit & (!mem_req | dhit);

  assign state  = state_q;
  assign halted = halted_q;

  // halted is kept as its own register, updated alongside state.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        HALTED: begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          if (advance && halt_in) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (mem_req && !dhit) begin
            state_q  <= MEMWAIT;
            halted_q <= 1'b0;
          end else begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    idex_wen    = 1'b0;
    exmem_wen   = 1'b0;
    memwb_wen   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (Rst || state_q == HALTED) begin
      // everything frozen
    end else if (advance && redirect) begin
      // squash the three younger instructions; PC takes the target
      pc_wen      = 1'b1;
      ifid_wen    = 1'b1;
      idex_wen    = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (advance && load_use) begin
      // hold PC and IF/ID, drop one bubble into ID/EX
      idex_wen    = 1'b1;
      idex_flush  = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
    end else if (advance) begin
      pc_wen      = 1'b1;
      ifid_wen    = 1'b1;
      idex_wen    = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
    end else if (mem_done && !ihit) begin
      // retire the memory op now and bubble EX/MEM so it is not reissued
      memwb_wen   = 1'b1;
      exmem_wen   = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      // a pending dcache access must not be written back yet
      memwb_wen   = !mem_req;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
    end else if (!advance && state_q != HALTED && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         ihit, dhit, mem_req, load_use, redirect, halt_in;
  logic         pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
  logic         ifid_flush, idex_flush, exmem_flush, halted;
  logic [1:0]   state;
  logic [W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.STALL_CNT_W(W)) dut (
    .clk(clk), .Rst(rst), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .load_use(load_use), .redirect(redirect), .halt_in(halt_in),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen),
    .exmem_wen(exmem_wen), .memwb_wen(memwb_wen), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halted(halted),
    .state(state), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {rst, ihit, dhit, mem_req, load_use, redirect, halt_in}
  // out = {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f, halted, state[1:0]}
  typedef struct packed {
    logic [6:0]  in;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[24];

  // reference model state
  bit     m_halted;
  bit     m_waiting;
  longint m_cnt;

  task automatic drive(input logic [6:0] in);
    {rst, ihit, dhit, mem_req, load_use, redirect, halt_in} = in;
  endtask

  function automatic logic [10:0] observed();
    return {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
            ifid_flush, idex_flush, exmem_flush, halted, state};
  endfunction

  task automatic check_out(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = observed();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input longint exp);
    n_checks++;
    if (stall_cycles !== exp[W-1:0]) begin
      n_fail++;
      $display("FAIL %s: stall_cycles got %0d required %0d", name, stall_cycles, exp);
    end
  endtask

  function automatic logic [10:0] model(input bit h, input bit w, input logic [6:0] in);
    bit r, ih, dh, mr, lu, rd;
    bit adv;
    logic [7:0] s;
    logic [1:0] st;
    {r, ih, dh, mr, lu, rd} = in[6:1];
    adv = !h && ih && (!mr || dh);
    st  = h ? 2'd2 : (w ? 2'd1 : 2'd0);
    if (r || h)                 s = 8'b00000000;
    else if (adv && rd)         s = 8'b11111111;
    else if (adv && lu)         s = 8'b00111010;
    else if (adv)               s = 8'b11111000;
    else if (mr && dh && !ih)   s = 8'b00011001;
    else                        s = {4'b0000, !mr, 3'b000};
    return {s, h, st};
  endfunction

  // advance model across one rising edge with inputs `in`
  task automatic model_step(input logic [6:0] in);
    bit r, ih, dh, mr, ht;
    bit adv;
    r = in[6]; ih = in[5]; dh = in[4]; mr = in[3]; ht = in[0];
    adv = !m_halted && ih && (!mr || dh);
    if (r) begin
      m_halted = 0; m_waiting = 0; m_cnt = 0;
    end else if (!m_halted) begin
      if (!adv) m_cnt = (m_cnt < (64'd1 << W) - 1) ? m_cnt + 1 : m_cnt;
      if (adv && ht) begin m_halted = 1; m_waiting = 0; end
      else m_waiting = mr && !dh;
    end
  endtask

  function automatic longint cnt_exp(input longint c);
`ifdef PIPE_STALL_CNT_EN
    return c;
`else
    return 0 + (c & 0);
`endif
  endfunction

  initial begin
    drive(7'b1111111);

    tbl[0]  = '{7'b1111111, 11'b00000000000};
    tbl[1]  = '{7'b1111111, 11'b00000000000};
    tbl[2]  = '{7'b0100000, 11'b11111000000};
    tbl[3]  = '{7'b0101000, 11'b00000000000};
    tbl[4]  = '{7'b0101000, 11'b00000000001};
    tbl[5]  = '{7'b0101000, 11'b00000000001};
    tbl[6]  = '{7'b0111000, 11'b11111000001};
    tbl[7]  = '{7'b0100000, 11'b11111000000};
    tbl[8]  = '{7'b0100100, 11'b00111010000};
    tbl[9]  = '{7'b0100000, 11'b11111000000};
    tbl[10] = '{7'b0100110, 11'b11111111000};
    tbl[11] = '{7'b0011000, 11'b00011001000};
    tbl[12] = '{7'b0000000, 11'b00001000000};
    tbl[13] = '{7'b0100001, 11'b11111000000};
    tbl[14] = '{7'b0100000, 11'b00000000110};
    tbl[15] = '{7'b1100000, 11'b00000000110};
    tbl[16] = '{7'b0100000, 11'b11111000000};
    tbl[17] = '{7'b0100011, 11'b11111111000};
    tbl[18] = '{7'b0100000, 11'b00000000110};
    tbl[19] = '{7'b1000000, 11'b00000000110};
    tbl[20] = '{7'b0110000, 11'b11111000000};
    tbl[21] = '{7'b0000010, 11'b00001000000};
    tbl[22] = '{7'b0101100, 11'b00000000000};
    tbl[23] = '{7'b0111110, 11'b11111111001};

    // table-driven sequence
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tbl[i].in);
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].exp);
    end

    // dcache miss of 3 cycles then completion; counter sees 3 stalls
    @(negedge clk); drive(7'b1100000);
    @(negedge clk); drive(7'b1100000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(7'b0101000); #1;
      check_out($sformatf("miss%0d", i), (i == 0) ? 11'b00000000000 : 11'b00000000001);
    end
    @(negedge clk); drive(7'b0111000); #1;
    check_out("miss_done", 11'b11111000001);
    check_cnt("miss_cnt_pre", cnt_exp(3));
    @(negedge clk); drive(7'b0100000); #1;
    check_out("miss_after", 11'b11111000000);
    check_cnt("miss_cnt", cnt_exp(3));

    // halt holds for 10 cycles with arbitrary inputs, then reset exits
    @(negedge clk); drive(7'b0100001); #1;
    check_out("halt_enter", 11'b11111000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); drive({1'b0, 6'($urandom)}); #1;
      check_out($sformatf("halt_hold%0d", i), 11'b00000000110);
    end
    check_cnt("halt_cnt", cnt_exp(3));
    @(negedge clk); drive(7'b1111111); #1;
    check_out("halt_rst", 11'b00000000110);
    @(negedge clk); drive(7'b0100000); #1;
    check_out("halt_exit", 11'b11111000000);
    check_cnt("cnt_cleared", cnt_exp(0));

    // randomized run against the reference model
    m_halted = 0; m_waiting = 0; m_cnt = 0;
    @(negedge clk); drive(7'b1000000); model_step(7'b1000000);
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] in;
      in = 7'($urandom);
      in[6] = ($urandom_range(0, 40) == 0);
      in[0] = ($urandom_range(0, 25) == 0);
      in[5] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      drive(in);
      #1;
      check_out($sformatf("rnd%0d", i), model(m_halted, m_waiting, in));
      check_cnt($sformatf("rnd_cnt%0d", i), cnt_exp(m_cnt));
      model_step(in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
